// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue: instruction fetch front end with an in-order response queue.
//
// Issues word-aligned fetch requests to instruction memory, tracks requests
// that are granted but not yet answered, and writes each response together
// with its fetch address into a small circular queue.
//
// The head of the queue drives the decode-side outputs. A redirect flushes
// the queue, retargets fetch, and discards responses to requests that were
// already in flight.
//
// Ports
//   clock, reset     : clock and asynchronous active-high reset
//   imem_req         : fetch request valid
//   imem_addr        : word-aligned fetch address
//   imem_gnt         : memory accepted the request this cycle
//   imem_rvalid      : response word valid
//   imem_rdata       : response instruction word
//   redirect         : taken jump/branch; flush and refetch
//   redirect_pc      : new fetch target
//   stall            : decode holds the current instruction
//   inst_valid       : inst_word/pc are meaningful (queue non-empty)
//   inst_word        : instruction at the queue head (0 when empty)
//   pc               : address of inst_word (holds its last value when empty)
//   pc_plus_4        : pc + 4, modulo 2^32
// ---------------------------------------------------------------------------

// Flags a response that arrives while no request is outstanding.
module ifetch_queue_chk (
    input logic clock,
    input logic reset,
    input logic imem_rvalid,
    input logic no_outstanding
);

    stray_rvalid_a : assert property (@(posedge clock) disable iff (reset)
        !(imem_rvalid && no_outstanding));

endmodule

module ifetch_queue #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          DEPTH       = 4,
    parameter bit          STRAY_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst_word,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  ZERO_C  = {CW{1'b0}};
    localparam logic [31:0]    ALIGN_M = 32'hFFFF_FFFC;

    // fetch_pc_r : next address to request
    // resp_pc_r  : address of the oldest live (non-discarded) outstanding request
    // last_pc_r  : last pc shown at the head, held on the outputs while empty
    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [31:0]   last_pc_r;
    logic [CW-1:0] live_cnt_r;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] q_cnt_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [63:0]   mem_r [DEPTH];

    logic [CW-1:0] outstanding_s;
    logic [CW-1:0] busy_cnt_s;
    logic          grant_s;
    logic          rsp_ok_s;
    logic          drop_hit_s;
    logic          push_s;
    logic          pop_s;
    logic          inst_valid_s;
    logic [63:0]   head_entry_s;
    logic [31:0]   target_pc_s;

    // Discarded-but-pending responses still occupy memory bandwidth and
    // reserve queue space, so they count toward the request throttle.
    assign outstanding_s = live_cnt_r + drop_cnt_r;
    assign busy_cnt_s    = q_cnt_r + outstanding_s;
    assign target_pc_s   = redirect_pc & ALIGN_M;

    assign imem_req   = !reset && !redirect && (busy_cnt_s < DEPTH_C);
    assign imem_addr  = fetch_pc_r & ALIGN_M;
    assign grant_s    = imem_req && imem_gnt;

    // A response with nothing outstanding is stray and is dropped here.
    assign rsp_ok_s   = imem_rvalid && (outstanding_s != ZERO_C);
    assign drop_hit_s = rsp_ok_s && (drop_cnt_r != ZERO_C);
    assign push_s     = rsp_ok_s && (drop_cnt_r == ZERO_C) && !redirect;

    assign inst_valid_s = (q_cnt_r != ZERO_C);
    assign pop_s        = inst_valid_s && !stall && !redirect;
    assign head_entry_s = mem_r[head_r];

    assign inst_valid = inst_valid_s;
    assign inst_word  = inst_valid_s ? head_entry_s[31:0]  : 32'h0000_0000;
    assign pc         = inst_valid_s ? head_entry_s[63:32] : last_pc_r;
    assign pc_plus_4  = pc + 32'd4;

    // Fetch address, request/drop accounting and queue pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC & ALIGN_M;
            live_cnt_r <= ZERO_C;
            drop_cnt_r <= ZERO_C;
            q_cnt_r    <= ZERO_C;
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
        end else if (redirect) begin
            // Every live request becomes a drop; a response landing in this
            // same cycle retires one of them immediately.
            fetch_pc_r <= target_pc_s;
            resp_pc_r  <= target_pc_s;
            live_cnt_r <= ZERO_C;
            drop_cnt_r <= outstanding_s - CW'(rsp_ok_s);
            q_cnt_r    <= ZERO_C;
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
        end else begin
            if (grant_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + 32'd4;
                tail_r    <= tail_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                head_r <= head_r + {{(AW-1){1'b0}}, 1'b1};
            end
            live_cnt_r <= live_cnt_r + CW'(grant_s) - CW'(push_s);
            drop_cnt_r <= drop_cnt_r - CW'(drop_hit_s);
            q_cnt_r    <= q_cnt_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Remember the pc on display so it stays visible once the queue drains.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_pc_r <= RESET_PC;
        end else if (inst_valid_s) begin
            last_pc_r <= head_entry_s[63:32];
        end
    end

    // Queue storage; contents are only observed while the entry is counted.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[tail_r] <= {resp_pc_r, imem_rdata};
        end
    end

    generate
        if (STRAY_CHECK) begin : g_chk
            ifetch_queue_chk u_chk (
                .clock          (clock),
                .reset          (reset),
                .imem_rvalid    (imem_rvalid),
                .no_outstanding (outstanding_s == ZERO_C)
            );
        end
    endgenerate

endmodule
